seq_magnitude_comparator: RTL and testbench
===========================================

# seq_magnitude_comparator

Parametrised, digit-serial magnitude comparator with a start/done handshake. It is the successor to the team's fixed 4-bit combinational comparator and serves the ALU datapath at wider operand widths. It supports signed and unsigned operands and examines DIGIT bits per cycle, starting from the most-significant digit. It terminates early at the first unequal digit and holds its g/e/l result until the next operation.

## Interface
- WIDTH, 8: operand width in bits. Must be ≥ 2.
- DIGIT, 2: bits compared per cycle. WIDTH must be divisible by DIGIT. NDIG = WIDTH/DIGIT.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a comparison; accepted only when busy=0
- signed_mode  in  1  1 = two's-complement compare; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while a comparison is in progress
- done  out  1  one-cycle pulse when g/e/l update
- g  out  1  A > B (registered, held)
- e  out  1  A == B (registered, held)
- l  out  1  A < B (registered, held)
- steps  out  $clog2(NDIG+1)  digits examined by the last comparison (held)

## Operation
- FSM states are IDLE and RUN.
- In IDLE, start=1 does the following:
  - Captures a and b into shift registers ra and rb.
  - If signed_mode=1, inverts bit WIDTH-1 of both captured operands. This maps the signed order onto the unsigned order.
  - Clears the digit counter and moves to RUN.
- In RUN, each cycle compares the top DIGIT bits of ra and rb (slice index = counter):
  - Top digit of ra > top digit of rb: set g=1, e=0, l=0 and return to IDLE.
  - Top digit of ra < top digit of rb: set l=1, e=0, g=0 and return to IDLE.
  - Digits equal and counter = NDIG-1: set e=1, g=0, l=0 and return to IDLE.
  - Digits equal otherwise: shift ra and rb left by DIGIT, increment the counter, and stay in RUN.
- On every return to IDLE, pulse done=1 and set steps = counter+1.
- Exactly one of g/e/l is 1 after the first completed comparison. All three are 0 only after reset.
- start while busy=1 is ignored. Operand and mode changes during RUN have no effect.
- rst=1 overrides everything, including mid-RUN:
  - The FSM returns to IDLE.
  - busy, done, g, e, l and steps are all 0.
  - The operation in progress is discarded and no done pulse is produced.

## Timing
- Define edge t as the edge where start=1 is sampled in IDLE. Then:
  - busy=1 from after edge t.
  - A comparison decided at slice i (0-based) updates g/e/l/steps and raises done after edge t+1+i.
  - busy=0 and state is IDLE in that same cycle.
- Latency from the start edge to the result is 1..NDIG cycles. The worst case (equal operands) is NDIG.
- done is high for exactly one cycle. g/e/l/steps hold until the next completed comparison.
- Back-to-back operation: start=1 in the cycle where done=1 is accepted at the next edge. There is no bubble beyond the single IDLE cycle.
- Reset values: busy=0, done=0, g=0, e=0, l=0, steps=0.

## Structure
- Package comparator_pkg contains:
  - The state enum: IDLE, RUN.
  - A packed result struct {g, e, l}.
  - The function used for the sign-bit flip.
- Sub-module cmp_slice is a combinational DIGIT-bit compare producing {g, e, l}. It is instantiated once on the top digits.
- The top level holds the FSM, the shift registers, the counter and the output registers. Estimated size is 150–250 lines.

## Test plan
Unless stated otherwise, WIDTH=8 and DIGIT=2.
- Equal operands, unsigned: a=0xA5, b=0xA5.
  - Required: e=1, g=0, l=0.
  - done arrives 4 cycles after the start edge. steps=4.
- Decided on the first digit:
  - a=0x80, b=0x7F, signed_mode=0: g=1, 1 cycle, steps=1.
  - Same operands with signed_mode=1: l=1, 1 cycle.
- Decided on the last digit: a=0x34, b=0x35, unsigned.
  - Required: l=1, steps=4.
  - Then start asserted in the done cycle with a=0xFF, b=0x01, signed_mode=1: l=1, steps=1.
- Protocol checks:
  - start pulsed again during busy with different operands: ignored, and the original result is reported.
  - rst asserted at cycle 2 of RUN: all outputs 0 the next cycle and no done pulse.
  - A new start after reset completes normally.
- Exhaustive sweep at WIDTH=4, DIGIT=1: all 256 (a, b) pairs in both modes.
  - Check g/e/l against a behavioural compare.
  - Check steps equals the index of the first differing bit plus 1, or 4 when a equals b.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package comparator_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } result_t;

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [MAX_WIDTH-1:0] flip_msb(input logic [MAX_WIDTH-1:0] v,
                                                    input int unsigned w);
    return v ^ (MAX_WIDTH'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module cmp_slice
  import comparator_pkg::*;
#(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output result_t          res_c
);

  always_comb begin
    res_c   = '0;
    res_c.g = (x > y);
    res_c.e = (x == y);
    res_c.l = (x < y);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial signed/unsigned magnitude comparator, MSB digit first, with
// early termination and a start/done handshake.
module seq_magnitude_comparator
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               signed_mode,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  output logic                               busy,
  output logic                               done,
  output logic                               g,
  output logic                               e,
  output logic                               l,
  output logic [$clog2(WIDTH/DIGIT+1)-1:0]   steps
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned SW   = $clog2(NDIG + 1);

  state_t           state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [CW-1:0]    cnt;
  result_t          slice_res_c;
  logic             last_c;

  assign last_c = (cnt == CW'(NDIG - 1));

  cmp_slice #(
    .DIGIT (DIGIT)
  ) u_slice (
    .x     (ra[WIDTH-1 -: DIGIT]),
    .y     (rb[WIDTH-1 -: DIGIT]),
    .res_c (slice_res_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b0;
      l     <= 1'b0;
      steps <= '0;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (signed_mode) begin
              ra <= WIDTH'(flip_msb(MAX_WIDTH'(a), WIDTH));
              rb <= WIDTH'(flip_msb(MAX_WIDTH'(b), WIDTH));
            end else begin
              ra <= a;
              rb <= b;
            end
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Stop at the first unequal digit, or after the last equal one.
          if (!slice_res_c.e || last_c) begin
            g     <= slice_res_c.g;
            e     <= slice_res_c.e;
            l     <= slice_res_c.l;
            steps <= SW'(cnt) + SW'(1);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            ra  <= ra << DIGIT;
            rb  <= rb << DIGIT;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Self-checking bench: directed table, protocol sequences, random and
// exhaustive sweeps checked against an arithmetic reference.
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // 8-bit, 2 bits per digit
  logic       start8, sm8;
  logic [7:0] a8, b8;
  logic       busy8, done8, g8, e8, l8;
  logic [2:0] steps8;
  // 4-bit, 1 bit per digit
  logic       start4, sm4;
  logic [3:0] a4, b4;
  logic       busy4, done4, g4, e4, l4;
  logic [2:0] steps4;

  int tests = 0;
  int fails = 0;

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .g(g8), .e(e8), .l(l8), .steps(steps8)
  );

  seq_magnitude_comparator #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .g(g4), .e(e4), .l(l4), .steps(steps4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    int         gel;    // g=4, e=2, l=1
    int         steps;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer compare of the operand values.
  function automatic int ref_gel(input int va, input int vb);
    if (va > vb) return 4;
    if (va == vb) return 2;
    return 1;
  endfunction

  // Reference: 1-based index of first differing digit from the MSB end.
  function automatic int ref_steps(input int diff, input int w, input int d);
    int mask = (1 << d) - 1;
    for (int k = 0; k < w / d; k++)
      if (((diff >> (w - d * (k + 1))) & mask) != 0) return k + 1;
    return w / d;
  endfunction

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi, input logic smi,
                      output int gel, output int st, output int lat);
    @(negedge clk);
    a8 = ai; b8 = bi; sm8 = smi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done8) lat = -1;
    gel = {29'd0, g8, e8, l8};
    st  = int'(steps8);
  endtask

  task automatic run4(input logic [3:0] ai, input logic [3:0] bi, input logic smi,
                      output int gel, output int st, output int lat);
    @(negedge clk);
    a4 = ai; b4 = bi; sm4 = smi; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done4) lat = -1;
    gel = {29'd0, g4, e4, l4};
    st  = int'(steps4);
  endtask

  vec_t vecs[9];

  initial begin
    int gel, st, lat, k, va, vb;
    logic [7:0] ra, rb;
    logic rsm;
    bit seen;

    vecs[0] = '{8'hA5, 8'hA5, 1'b0, 2, 4};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 4, 1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 1, 1};
    vecs[3] = '{8'h34, 8'h35, 1'b0, 1, 4};
    vecs[4] = '{8'hFF, 8'h01, 1'b1, 1, 1};  // issued in the done cycle of [3]
    vecs[5] = '{8'h00, 8'h00, 1'b1, 2, 4};
    vecs[6] = '{8'h7F, 8'h80, 1'b1, 4, 1};
    vecs[7] = '{8'hFE, 8'hFF, 1'b1, 1, 4};
    vecs[8] = '{8'h0C, 8'h08, 1'b0, 4, 3};

    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset8_busy", busy8, 0);
    check("reset8_done", done8, 0);
    check("reset8_gel", {g8, e8, l8}, 0);
    check("reset8_steps", steps8, 0);
    check("reset4_gel", {g4, e4, l4}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table; consecutive runs are back-to-back (start in done cycle).
    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].sm, gel, st, lat);
      check($sformatf("vec%0d_gel", i), gel, vecs[i].gel);
      check($sformatf("vec%0d_steps", i), st, vecs[i].steps);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].steps);
    end

    // start re-pulsed while busy with other operands must be ignored.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h06; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("busy_after_start", busy8, 1);
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (k <= 2) begin
        a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b1; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      if (done8) break;
    end
    start8 = 1'b0;
    check("ignore_latency", k, 4);
    check("ignore_gel", {g8, e8, l8}, 1);
    check("ignore_steps", steps8, 4);
    @(posedge clk); #1;
    check("done_one_cycle", done8, 0);
    check("idle_after_done", busy8, 0);

    // Reset in the middle of a run.
    @(negedge clk);
    a8 = 8'hA5; b8 = 8'hA5; sm8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", busy8, 0);
    check("midrst_done", done8, 0);
    check("midrst_gel", {g8, e8, l8}, 0);
    check("midrst_steps", steps8, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen = 1'b1;
    end
    check("midrst_no_done", seen, 0);
    run8(8'h12, 8'h34, 1'b0, gel, st, lat);
    check("after_rst_gel", gel, 1);
    check("after_rst_steps", st, 2);
    check("after_rst_latency", lat, 2);

    // Random 8-bit operands against the arithmetic reference.
    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom);
      rb = (n % 8 == 0) ? ra : 8'($urandom);
      rsm = 1'($urandom);
      va = rsm ? int'($signed(ra)) : int'(ra);
      vb = rsm ? int'($signed(rb)) : int'(rb);
      run8(ra, rb, rsm, gel, st, lat);
      check($sformatf("rnd%0d_gel a=%h b=%h s=%0d", n, ra, rb, rsm), gel, ref_gel(va, vb));
      check($sformatf("rnd%0d_steps", n), st, ref_steps(int'(ra ^ rb), 8, 2));
      check($sformatf("rnd%0d_latency", n), lat, ref_steps(int'(ra ^ rb), 8, 2));
    end

    // Exhaustive 4-bit, 1 bit per digit, both modes.
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          va = (m == 1 && x >= 8) ? x - 16 : x;
          vb = (m == 1 && y >= 8) ? y - 16 : y;
          run4(4'(x), 4'(y), 1'(m), gel, st, lat);
          check($sformatf("ex_m%0d_%0d_%0d_gel", m, x, y), gel, ref_gel(va, vb));
          check($sformatf("ex_m%0d_%0d_%0d_steps", m, x, y), st, ref_steps(x ^ y, 4, 1));
          check($sformatf("ex_m%0d_%0d_%0d_latency", m, x, y), lat, ref_steps(x ^ y, 4, 1));
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
